// File: rtl/octave_scan_if.sv
// Pyramid-controller / image-RAM / window-generator signal bundle for octave_scan_ctrl.
// Handshake: start is a one-cycle request taken only when busy=0 and done=0; busy covers the whole pass,
// done pulses once when a pass completes; ram_rd and pix_vld are single-cycle strobes qualifying their buses.
interface octave_scan_if #(
    parameter int IMG_LOG2 = 9
);
    logic                    start;
    logic [1:0]              octave;
    logic                    abort;
    logic                    stall;
    logic                    busy;
    logic                    done;
    logic [2*IMG_LOG2-1:0]   ram_addr;
    logic                    ram_rd;
    logic                    pix_vld;
    logic                    pix_last;
    logic                    win_vld;
    logic [IMG_LOG2-1:0]     win_row;
    logic [IMG_LOG2-1:0]     win_col;

    modport master (
        output start, octave, abort, stall,
        input  busy, done, ram_addr, ram_rd, pix_vld, pix_last, win_vld, win_row, win_col
    );

    modport slave (
        input  start, octave, abort, stall,
        output busy, done, ram_addr, ram_rd, pix_vld, pix_last, win_vld, win_row, win_col
    );
endinterface

// File: rtl/octave_scan_ctrl.sv
// Raster read sequencer for one octave pass of the image RAM, with delivery tracking that
// flags pixels completing a KSIZE x KSIZE window and reports the window centre.
module octave_scan_ctrl #(
    parameter int IMG_LOG2 = 9,
    parameter int KSIZE    = 11,
    parameter int RAM_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    octave_scan_if.slave       bus,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [IMG_LOG2-1:0] BORDER    = IMG_LOG2'(KSIZE - 1);
    localparam logic [IMG_LOG2-1:0] HALF      = IMG_LOG2'((KSIZE - 1) / 2);
    localparam logic [IMG_LOG2-1:0] ONE       = IMG_LOG2'(1);
    localparam logic [RAM_LAT-1:0]  OUT_STAGE = RAM_LAT'(1) << (RAM_LAT - 1);

    state_e                state_q, state_d;
    logic [1:0]            oct_q, oct_d;
    logic [IMG_LOG2-1:0]   ir_q, ir_d, ic_q, ic_d;
    logic [IMG_LOG2-1:0]   dr_q, dr_d, dc_q, dc_d;
    logic [RAM_LAT-1:0]    sr_q, sr_d;
    logic                  last_q, last_d, win_q, win_d;
    logic [IMG_LOG2-1:0]   row_q, row_d, col_q, col_d;

    logic [IMG_LOG2-1:0]   side_last;
    logic                  issue;
    logic                  in_flight;
    logic                  entering;
    logic                  win_hit;
    logic [RAM_LAT:0]      chain;

    // N-1 for the latched octave: all-ones shifted down by the octave.
    assign side_last = {IMG_LOG2{1'b1}} >> oct_q;
    assign issue     = (state_q == SCAN) && !bus.stall && !bus.abort;
    assign chain     = {sr_q, issue};
    assign entering  = chain[RAM_LAT-1];
    assign in_flight = |(sr_q & ~OUT_STAGE);
    assign win_hit   = (dr_q >= BORDER) && (dc_q >= BORDER);

    always_comb begin
        state_d = state_q;
        oct_d   = oct_q;
        ir_d    = ir_q;
        ic_d    = ic_q;
        dr_d    = dr_q;
        dc_d    = dc_q;
        sr_d    = chain[RAM_LAT-1:0];
        last_d  = 1'b0;
        win_d   = 1'b0;
        row_d   = '0;
        col_d   = '0;

        // Window metadata is computed as a read enters the final delay stage so it lines up with pix_vld.
        if (entering) begin
            last_d = (dr_q == side_last) && (dc_q == side_last);
            win_d  = win_hit;
            if (win_hit) begin
                row_d = dr_q - HALF;
                col_d = dc_q - HALF;
            end
            if (dc_q == side_last) begin
                dc_d = '0;
                dr_d = dr_q + ONE;
            end else begin
                dc_d = dc_q + ONE;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    oct_d   = bus.octave;
                    ir_d    = '0;
                    ic_d    = '0;
                    dr_d    = '0;
                    dc_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (ic_q == side_last) begin
                        ic_d = '0;
                        if (ir_q == side_last) begin
                            ir_d    = '0;
                            state_d = FLUSH;
                        end else begin
                            ir_d = ir_q + ONE;
                        end
                    end else begin
                        ic_d = ic_q + ONE;
                    end
                end
            end
            FLUSH: begin
                if (!in_flight) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort discards everything in flight so nothing is delivered after the cancel.
        if (bus.abort && (state_q == SCAN || state_q == FLUSH)) begin
            state_d = IDLE;
            ir_d    = '0;
            ic_d    = '0;
            sr_d    = '0;
            last_d  = 1'b0;
            win_d   = 1'b0;
            row_d   = '0;
            col_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            oct_q   <= '0;
            ir_q    <= '0;
            ic_q    <= '0;
            dr_q    <= '0;
            dc_q    <= '0;
            sr_q    <= '0;
            last_q  <= 1'b0;
            win_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            oct_q   <= oct_d;
            ir_q    <= ir_d;
            ic_q    <= ic_d;
            dr_q    <= dr_d;
            dc_q    <= dc_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
            win_q   <= win_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign bus.busy     = (state_q == SCAN) || (state_q == FLUSH);
    assign bus.done     = (state_q == DONE);
    assign bus.ram_rd   = issue;
    assign bus.ram_addr = {ir_q << oct_q, ic_q << oct_q};
    assign bus.pix_vld  = chain[RAM_LAT];
    assign bus.pix_last = last_q;
    assign bus.win_vld  = win_q;
    assign bus.win_row  = row_q;
    assign bus.win_col  = col_q;
    assign dbg_state_o  = state_q;
endmodule
